mem_stream_reader: RTL and testbench
====================================

Name: mem_stream_reader

Overview:
- Read-side initiator for the byte-addressable memory port used by the program loader and the single-cycle CPU.
- The loader writes an image into memory one byte at a time. This block does the reverse: given a start address and a byte count, it reads memory bytes in order and streams them out on a valid/ready byte stream.
- Uses: image readback, memory dumps and checksum verification after loading.
- It drives only the address of a combinational read port; it never writes memory.

Parameters:
- MEM_START, 32'h80000000, first valid byte address of the memory window.
- MEM_SIZE, 8192, window size in bytes; valid addresses are [MEM_START, MEM_START+MEM_SIZE).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- start_addr  input  32  first byte address, captured on accept.
- byte_count  input  32  number of bytes to stream, captured on accept.
- busy  output  1  high from accept until the done cycle (inclusive).
- done  output  1  one-cycle completion pulse.
- err  output  1  range error of the last request; held until the next accept.
- mem_addr  output  32  registered read address to memory.
- mem_rd  input  32  combinational read data; bits [7:0] are the byte at mem_addr.
- out_valid  output  1  out_data holds a byte.
- out_ready  input  1  consumer accepts the byte.
- out_data  output  8  streamed byte.
- checksum  output  32  running sum of accepted bytes, mod 2^32.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State=IDLE.
  - busy=0, done=0, err=0, out_valid=0, out_data=0, checksum=0, mem_addr=0.
  - Internal address and remaining-count registers cleared.
  - Reset asserted mid-stream aborts the transfer immediately: no done pulse, no byte delivered.
- States: IDLE, RUN, FIN.
- IDLE, start=1 at edge N (accept):
  - Clear checksum and err.
  - Range check in 33-bit arithmetic. The request fails if start_addr < MEM_START, or start_addr + byte_count > MEM_START + MEM_SIZE.
  - Fail -> err=1, go to FIN. No memory reads, no out_valid.
  - byte_count=0 and in range -> go to FIN, err=0.
  - Otherwise -> mem_addr=start_addr, remaining=byte_count, go to RUN.
- RUN, fetch condition F = (remaining != 0) && (!out_valid || out_ready). On an edge where F=1:
  - out_data <= mem_rd[7:0];
  - out_valid <= 1;
  - mem_addr <= mem_addr + 1;
  - remaining <= remaining - 1.
- RUN, handshake H = out_valid && out_ready:
  - On H, checksum <= checksum + out_data (zero-extended).
  - If H occurs and F=0, then out_valid <= 0.
- Stream rules:
  - While out_valid=1 and out_ready=0, out_data is held stable.
  - First out_valid=1 is in the cycle after edge N+1.
  - Throughput is one byte per cycle while out_ready=1.
- RUN exits to FIN on the edge where remaining=0 and the final byte's handshake completes. out_valid=0 afterwards.
- FIN:
  - done=1 and busy=1 for exactly one cycle, then IDLE with busy=0.
  - checksum holds its final value until the next accept.
- start while busy=1 (RUN or FIN) is ignored; start_addr and byte_count are not re-sampled.
- mem_addr never leaves the validated window during RUN. After the last fetch it may equal the end address; it is not dereferenced.
- remaining and mem_addr are 32-bit; no wrap can occur because of the range check.

Test Plan:
- Reset: hold reset_n=0 mid-RUN, asynchronously -> all outputs at reset values before the next clk edge. After release, start with byte_count=0 -> one-cycle done, err=0, no out_valid.
- Basic readback:
  - Stimulus: memory at 0x80000000..3 = 13,05,00,00; out_ready=1; start_addr=0x80000000, byte_count=4.
  - Response: out_data 0x13,0x05,0x00,0x00 on four consecutive cycles; first valid two cycles after accept; checksum=0x18; single done pulse.
- Backpressure:
  - Stimulus: bytes 0xFF×3 at 0x80000100; out_ready pattern 0,1,0,0,1,1.
  - Response: out_data stable while stalled; exactly 3 handshakes; checksum=0x2FD.
- Range errors:
  - start_addr=0x80001FFF, byte_count=2 -> err=1, done pulse, no out_valid.
  - start_addr=0x7FFFFFFF, byte_count=1 -> err=1.
  - start_addr=0x80001FFF, byte_count=1 -> one byte, err=0.
- Start while busy: pulse start with different start_addr during RUN -> ignored; original stream and checksum unchanged.
- Full window: start_addr=0x80000000, byte_count=8192, out_ready random 50% -> all 8192 bytes match memory; checksum equals the software sum.

Source files
------------

// File: rtl/mem_stream_reader.sv
// Streams a validated window of byte-addressable memory onto a valid/ready byte
// stream and keeps a running checksum of the bytes the consumer accepts.
module mem_stream_reader #(
    parameter logic [31:0] MEM_START = 32'h8000_0000,
    parameter int unsigned MEM_SIZE  = 8192
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] start_addr,
    input  logic [31:0] byte_count,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [31:0] checksum
);

    localparam int unsigned LP_AW      = 32;
    localparam int unsigned LP_BW      = 8;
    localparam logic [LP_AW:0] LP_WIN_LO  = (LP_AW+1)'(MEM_START);
    localparam logic [LP_AW:0] LP_WIN_END = (LP_AW+1)'(MEM_START) + (LP_AW+1)'(MEM_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [LP_AW-1:0]   r_mem_addr;
    logic [LP_AW-1:0]   r_remaining;
    logic [LP_AW-1:0]   r_checksum;
    logic [LP_BW-1:0]   r_out_data;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic               w_accept;
    logic               w_range_err;
    logic               w_empty_req;
    logic               w_fetch;
    logic               w_hs;
    logic               w_last;
    logic               w_unused;

    // Range check is done in 33 bits so start_addr + byte_count cannot wrap.
    assign w_range_err = ({1'b0, start_addr} < LP_WIN_LO) ||
                         (({1'b0, start_addr} + {1'b0, byte_count}) > LP_WIN_END);
    assign w_empty_req = (byte_count == '0);
    assign w_accept    = (r_state == ST_IDLE) && start;
    assign w_fetch     = (r_state == ST_RUN) && (r_remaining != '0) && (!r_out_valid || out_ready);
    assign w_hs        = (r_state == ST_RUN) && r_out_valid && out_ready;
    assign w_last      = w_hs && (r_remaining == '0);
    assign w_unused    = ^mem_rd[LP_AW-1:LP_BW];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_range_err || w_empty_req) begin
                        w_state_next = ST_FIN;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_FIN;
                end
            end
            ST_FIN:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State plus status flags derived from the upcoming state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != ST_IDLE);
            r_done  <= (w_state_next == ST_FIN);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_addr  <= '0;
            r_remaining <= '0;
            r_checksum  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_checksum <= '0;
                r_err      <= w_range_err;
                if (!w_range_err && !w_empty_req) begin
                    r_mem_addr  <= start_addr;
                    r_remaining <= byte_count;
                end
            end

            // A fetch refills the output slot; a bare handshake empties it.
            if (w_fetch) begin
                r_out_data  <= mem_rd[LP_BW-1:0];
                r_out_valid <= 1'b1;
                r_mem_addr  <= r_mem_addr + LP_AW'(1);
                r_remaining <= r_remaining - LP_AW'(1);
            end else if (w_hs) begin
                r_out_valid <= 1'b0;
            end

            if (w_hs) begin
                r_checksum <= r_checksum + LP_AW'(r_out_data);
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign mem_addr  = r_mem_addr;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign checksum  = r_checksum;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader: table of requests with hand-computed
// results, plus reset-abort and full-window sequences.
module tb_mem_stream_reader;

    localparam logic [31:0] MEM_BASE = 32'h8000_0000;
    localparam int          MEM_N    = 8192;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] start_addr;
    logic [31:0] byte_count;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] mem_addr;
    logic [31:0] mem_rd;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [31:0] checksum;

    logic [7:0]  mem [0:MEM_N-1];

    int n_checks;
    int n_fail;

    mem_stream_reader #(
        .MEM_START (MEM_BASE),
        .MEM_SIZE  (MEM_N)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .byte_count (byte_count),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational memory; upper bits carry junk the DUT must ignore.
    always_comb begin
        if (mem_addr >= MEM_BASE && mem_addr < MEM_BASE + 32'(MEM_N))
            mem_rd = {24'hA5C3E1, mem[13'(mem_addr - MEM_BASE)]};
        else
            mem_rd = 32'hDEAD_BEEF;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] count;
        logic        exp_err;
        int          exp_n;
        logic [31:0] exp_sum;
        int          mode;   // 0: ready=1, 1: stall pattern, 2: random, 3: start while busy
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_req(input logic [31:0] a, input logic [31:0] n, input logic exp_err,
                           input int exp_n, input logic [31:0] exp_sum, input int mode);
        int          hs;
        int          first_valid;
        bit          fin;
        logic        pv;
        logic        pr;
        logic        r;
        logic [7:0]  pd;
        logic        pat [0:5];
        pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        hs = 0;
        first_valid = -1;
        fin = 0;
        pv = 1'b0;
        pr = 1'b0;
        pd = '0;

        @(negedge clk);
        start = 1'b1;
        start_addr = a;
        byte_count = n;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_addr = 32'h0BAD_0000;
        byte_count = 32'h55;
        check("busy_after_accept", 32'(busy), 32'd1);

        for (int idx = 1; idx <= 40000 && !fin; idx++) begin
            if (idx > 1) @(negedge clk);
            if (pv && !pr) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(pd));
            end
            if (out_valid && first_valid < 0) first_valid = idx;
            case (mode)
                1:       r = (idx <= 6) ? pat[idx-1] : 1'b1;
                2:       r = 1'($urandom_range(0, 1));
                default: r = 1'b1;
            endcase
            if (mode == 3) begin
                if (idx == 3) begin
                    start = 1'b1;
                    start_addr = 32'h8000_0100;
                    byte_count = 32'd3;
                end else if (idx == 4) begin
                    start = 1'b0;
                end
            end
            out_ready = r;
            if (out_valid && r) begin
                check("data", 32'(out_data), 32'(mem[13'(a - MEM_BASE + 32'(hs))]));
                hs++;
            end
            if (done) begin
                check("busy_in_done", 32'(busy), 32'd1);
                check("err_in_done", 32'(err), 32'(exp_err));
                fin = 1;
            end
            pv = out_valid;
            pr = r;
            pd = out_data;
        end
        start = 1'b0;
        if (!fin) check("done_timeout", 32'd0, 32'd1);

        @(negedge clk);
        check("done_single", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("valid_idle", 32'(out_valid), 32'd0);
        check("err_held", 32'(err), 32'(exp_err));
        check("checksum", checksum, exp_sum);
        check("handshakes", 32'(hs), 32'(exp_n));
        check("first_valid_latency", 32'(first_valid), (exp_n > 0) ? 32'd2 : 32'hFFFF_FFFF);
        @(negedge clk);
        check("no_restart", 32'(busy), 32'd0);
    endtask

    vec_t        vecs [0:7];
    logic [31:0] sw_sum;

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset_n = 1'b0;
        start = 1'b0;
        start_addr = '0;
        byte_count = '0;
        out_ready = 1'b0;

        for (int i = 0; i < MEM_N; i++) mem[i] = 8'(i * 7 + 3);
        mem[0] = 8'h13;
        mem[1] = 8'h05;
        mem[2] = 8'h00;
        mem[3] = 8'h00;
        mem[256] = 8'hFF;
        mem[257] = 8'hFF;
        mem[258] = 8'hFF;
        mem[8191] = 8'h5A;

        vecs[0] = '{32'h8000_0000, 32'd0, 1'b0, 0, 32'h0,   0};
        vecs[1] = '{32'h8000_0000, 32'd4, 1'b0, 4, 32'h18,  0};
        vecs[2] = '{32'h8000_0100, 32'd3, 1'b0, 3, 32'h2FD, 1};
        vecs[3] = '{32'h8000_1FFF, 32'd2, 1'b1, 0, 32'h0,   0};
        vecs[4] = '{32'h7FFF_FFFF, 32'd1, 1'b1, 0, 32'h0,   0};
        vecs[5] = '{32'h8000_1FFF, 32'd1, 1'b0, 1, 32'h5A,  0};
        vecs[6] = '{32'hFFFF_FFFF, 32'd2, 1'b1, 0, 32'h0,   0};
        vecs[7] = '{32'h8000_0000, 32'd4, 1'b0, 4, 32'h18,  3};

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        reset_n = 1'b1;

        // Abort a running transfer with an asynchronous reset between edges.
        @(negedge clk);
        start = 1'b1;
        start_addr = MEM_BASE;
        byte_count = 32'd100;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_abort_valid", 32'(out_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_data", 32'(out_data), 32'd0);
        check("abort_checksum", checksum, 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_abort_done", 32'(done), 32'd0);
            check("post_abort_valid", 32'(out_valid), 32'd0);
        end

        for (int v = 0; v < 8; v++)
            run_req(vecs[v].addr, vecs[v].count, vecs[v].exp_err, vecs[v].exp_n,
                    vecs[v].exp_sum, vecs[v].mode);

        sw_sum = '0;
        for (int i = 0; i < MEM_N; i++) sw_sum = sw_sum + 32'(mem[i]);
        run_req(MEM_BASE, 32'(MEM_N), 1'b0, MEM_N, sw_sum, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
